conv_mc_engine: RTL and testbench
=================================

CONV_MC_ENGINE -- requirements
Module: conv_mc_engine

Interface
REQ-001 Parameter N, default 8: pixel, kernel and output word width in bits.
REQ-002 Parameter P, default 5: square image side; output side is P-2.
REQ-003 Parameter C, default 2: input channel count, at least 1.
REQ-004 Parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before saturation.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  a one-cycle pulse begins a job.
REQ-008 kern_valid / kern_ready  input / output  1 / 1  kernel load handshake.
REQ-009 kern_data  input  N  kernel coefficient, two's complement.
REQ-010 pix_valid / pix_ready  input / output  1 / 1  pixel load handshake.
REQ-011 pix_data  input  N  pixel, unsigned.
REQ-012 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-013 out_data  output  N  saturated result.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a job completes.

Function
REQ-016 The FSM SHALL use the states IDLE, LOAD_K, LOAD_PIX, COMPUTE, OUT and FIN.
- IDLE->LOAD_K on start.
- start SHALL be ignored while busy.
REQ-017 LOAD_K: kern_ready=1; 9*C words are accepted on cycles where kern_valid&kern_ready.
- Order: channel-major, row-major within each 3x3.
- After the last word the FSM SHALL go to LOAD_PIX.
REQ-018 LOAD_PIX: pix_ready=1; P*P*C words are accepted, channel-major, row-major.
- After the last word the FSM SHALL go to COMPUTE.
REQ-019 COMPUTE: one channel per cycle, 9 parallel multiplies.
- Each product is unsigned pixel x signed coefficient, sign-extended into a signed accumulator of width 2N+5+clog2(C).
- The accumulator SHALL NOT overflow.
- Output positions are raster order, row 0..P-3, col 0..P-3.
REQ-020 After C accumulate cycles the next edge SHALL register out_data, set out_valid=1 and enter OUT.
- Latency from entering COMPUTE for a position to out_valid is C+1 cycles.
REQ-021 OUT: out_data and out_valid SHALL hold stable until out_ready=1.
- On the handshake: return to COMPUTE for the next position, or go to FIN after position (P-2)^2-1.
- out_valid SHALL drop the edge after the handshake.
REQ-022 FIN: done=1 for one cycle, then IDLE.
- A start in the FIN cycle SHALL be ignored.
REQ-023 Result = accumulator >>> SHIFT, then saturated per REQ-030.
REQ-024 kern_ready and pix_ready SHALL be 0 outside their states; valid without ready SHALL have no effect.

Reset
REQ-025 While rst=0, the FSM SHALL be IDLE and every counter and the accumulator SHALL be 0.
REQ-026 Reset values: busy, done, out_valid, kern_ready and pix_ready = 0; out_data = 0.
REQ-027 Reset SHALL abort any phase immediately, mid-load or mid-output; no partial done pulse follows.
REQ-028 Kernel and pixel storage need not be cleared by reset; every job reloads it fully.

Configuration
REQ-029 The macro CONV_MC_RELU_EN, when defined, SHALL clamp negative results to 0 and saturate positive results to 2^N-1, giving unsigned out_data.
REQ-030 Without CONV_MC_RELU_EN, out_data SHALL be signed, saturated to [-2^(N-1), 2^(N-1)-1].

Verification
All scenarios use N=8, P=5, C=2, SHIFT=0.
REQ-031 All pixels 1, all coefficients 1 -> nine outputs, each 18; done pulses once after the ninth handshake.
REQ-032 Pixels 255, coefficients 127 -> every output 127 without the macro, 255 with it.
REQ-033 Pixels 10, coefficients -1 -> every output -128 (0x80) without the macro, 0 with it.
REQ-034 out_ready=0 for 5 cycles at the first output -> out_data is stable, no new kernel or pixel handshakes, and all 9 outputs arrive in raster order.
REQ-035 rst low for 1 cycle during COMPUTE -> all outputs 0 and IDLE next cycle; a new start with REQ-031 data then gives nine outputs of 18.
REQ-036 start pulsed during LOAD_PIX -> ignored; the job completes with exactly one done pulse.

Source files
------------

// File: rtl/conv_mc_engine_if.sv
// ---------------------------------------------------------------------------
// conv_mc_engine_if
// Bundles the job control, load handshakes and result handshake of the
// multi-channel 3x3 convolution engine.
//   master : driven by whoever feeds the engine (testbench / upstream logic)
//   slave  : the engine itself
// Signals:
//   start                       one-cycle job start pulse (master -> slave)
//   kern_valid/kern_ready/data  kernel coefficient stream, two's complement
//   pix_valid/pix_ready/data    pixel stream, unsigned
//   out_valid/out_ready/data    saturated result stream
//   busy                        engine not idle
//   done                        one-cycle pulse at job completion
// ---------------------------------------------------------------------------
interface conv_mc_engine_if #(
    parameter int N = 8
);
    logic         start;
    logic         kern_valid;
    logic         kern_ready;
    logic [N-1:0] kern_data;
    logic         pix_valid;
    logic         pix_ready;
    logic [N-1:0] pix_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         busy;
    logic         done;

    modport master (
        output start, kern_valid, kern_data, pix_valid, pix_data, out_ready,
        input  kern_ready, pix_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, kern_valid, kern_data, pix_valid, pix_data, out_ready,
        output kern_ready, pix_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/conv_mc_engine.sv
// ---------------------------------------------------------------------------
// conv_mc_engine
// Multi-channel 3x3 "valid" convolution over a P x P image with C channels.
// A job loads 9*C kernel words, then P*P*C pixel words (both channel-major,
// row-major), then produces (P-2)^2 results in raster order. Each result is
// accumulated one channel per cycle with nine parallel multiplies, shifted
// right by SHIFT and saturated to N bits.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  conv_mc_engine_if.slave (start, kernel/pixel/result handshakes,
//        busy, done)
// Configuration:
//   CONV_MC_RELU_EN  when defined, results are clamped to [0, 2^N-1]
//                    (unsigned); otherwise saturated to signed N bits.
// ---------------------------------------------------------------------------
module conv_mc_engine #(
    parameter int N     = 8,
    parameter int P     = 5,
    parameter int C     = 2,
    parameter int SHIFT = 0
) (
    input logic             clk,
    input logic             rst,
    conv_mc_engine_if.slave bus
);
    // Accumulator width: 9*C products of (N+1)x N bits never overflow it.
    localparam int AW  = 2 * N + 5 + $clog2(C);
    localparam int PW  = 2 * N + 1;
    localparam int PIW = (P * P * C > 1) ? $clog2(P * P * C) : 1;
    localparam int KIW = $clog2(9 * C);
    localparam int LW  = PIW;
    localparam int CW  = $clog2(C + 1);
    localparam int RW  = $clog2(P);

    localparam logic [LW-1:0] K_LAST  = LW'(9 * C - 1);
    localparam logic [LW-1:0] P_LAST  = LW'(P * P * C - 1);
    localparam logic [CW-1:0] CH_DONE = CW'(C);
    localparam logic [RW-1:0] RC_LAST = RW'(P - 3);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        LOAD_PIX,
        COMPUTE,
        OUT,
        FIN
    } state_t;

    state_t                 state;
    logic [LW-1:0]          load_cnt;
    logic [CW-1:0]          ch_cnt;
    logic [RW-1:0]          row;
    logic [RW-1:0]          col;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   win_sum;
    logic [PIW-1:0]         pix_idx;
    logic [KIW-1:0]         kern_idx;
    logic signed [PW-1:0]   prod;
    logic                   kern_ready_q;
    logic                   pix_ready_q;
    logic                   out_valid_q;
    logic [N-1:0]           out_data_q;
    logic                   busy_q;
    logic                   done_q;

    logic [N-1:0]           pix_mem  [P*P*C];
    logic signed [N-1:0]    kern_mem [9*C];

    assign bus.kern_ready = kern_ready_q;
    assign bus.pix_ready  = pix_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // Scale the accumulator down to N bits, clamping out-of-range values.
    function automatic logic [N-1:0] saturate(input logic signed [AW-1:0] v);
`ifdef CONV_MC_RELU_EN
        logic signed [AW-1:0] relu_max;
        relu_max = (AW'(1) <<< N) - AW'(1);
        if (v[AW-1])
            return '0;
        else if (v > relu_max)
            return '1;
        else
            return v[N-1:0];
`else
        logic signed [AW-1:0] sat_hi;
        logic signed [AW-1:0] sat_lo;
        sat_hi = (AW'(1) <<< (N - 1)) - AW'(1);
        sat_lo = ~sat_hi;
        if (v > sat_hi)
            return {1'b0, {(N-1){1'b1}}};
        else if (v < sat_lo)
            return {1'b1, {(N-1){1'b0}}};
        else
            return v[N-1:0];
`endif
    endfunction

    // Coefficient and pixel storage; every job overwrites all of it, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD_K && bus.kern_valid)
            kern_mem[KIW'(load_cnt)] <= $signed(bus.kern_data);
        if (state == LOAD_PIX && bus.pix_valid)
            pix_mem[PIW'(load_cnt)] <= bus.pix_data;
    end

    // Sum of the nine window products for the channel currently selected.
    // The pixel is zero-extended before the signed multiply so 255 stays 255.
    always_comb begin
        int ch_i;
        win_sum  = '0;
        pix_idx  = '0;
        kern_idx = '0;
        prod     = '0;
        ch_i     = (int'(ch_cnt) < C) ? int'(ch_cnt) : 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pix_idx  = PIW'(ch_i * P * P + (int'(row) + i) * P + int'(col) + j);
                kern_idx = KIW'(ch_i * 9 + i * 3 + j);
                prod     = PW'($signed({1'b0, pix_mem[pix_idx]})) * PW'(kern_mem[kern_idx]);
                win_sum  = win_sum + AW'(prod);
            end
        end
    end

    // Control FSM. COMPUTE spends C cycles accumulating and one more cycle
    // registering the saturated result, so out_valid appears C+1 cycles
    // after each entry into COMPUTE. All outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            load_cnt     <= '0;
            ch_cnt       <= '0;
            row          <= '0;
            col          <= '0;
            acc          <= '0;
            kern_ready_q <= 1'b0;
            pix_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state        <= LOAD_K;
                        busy_q       <= 1'b1;
                        kern_ready_q <= 1'b1;
                        load_cnt     <= '0;
                    end
                end
                LOAD_K: begin
                    if (bus.kern_valid) begin
                        if (load_cnt == K_LAST) begin
                            load_cnt     <= '0;
                            kern_ready_q <= 1'b0;
                            pix_ready_q  <= 1'b1;
                            state        <= LOAD_PIX;
                        end else begin
                            load_cnt <= load_cnt + LW'(1);
                        end
                    end
                end
                LOAD_PIX: begin
                    if (bus.pix_valid) begin
                        if (load_cnt == P_LAST) begin
                            load_cnt    <= '0;
                            pix_ready_q <= 1'b0;
                            ch_cnt      <= '0;
                            row         <= '0;
                            col         <= '0;
                            acc         <= '0;
                            state       <= COMPUTE;
                        end else begin
                            load_cnt <= load_cnt + LW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (ch_cnt != CH_DONE) begin
                        acc    <= acc + win_sum;
                        ch_cnt <= ch_cnt + CW'(1);
                    end else begin
                        out_data_q  <= saturate(acc >>> SHIFT);
                        out_valid_q <= 1'b1;
                        acc         <= '0;
                        ch_cnt      <= '0;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (row == RC_LAST && col == RC_LAST) begin
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else begin
                            state <= COMPUTE;
                            if (col == RC_LAST) begin
                                col <= '0;
                                row <= row + RW'(1);
                            end else begin
                                col <= col + RW'(1);
                            end
                        end
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mc_engine.sv
// ---------------------------------------------------------------------------
// tb_conv_mc_engine
// Directed self-checking bench for conv_mc_engine with N=8, P=5, C=2,
// SHIFT=0. Expected results follow the CONV_MC_RELU_EN build setting.
// ---------------------------------------------------------------------------
module tb_conv_mc_engine;
    localparam int N = 8;
    localparam int P = 5;
    localparam int C = 2;
`ifdef CONV_MC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    conv_mc_engine_if #(.N(N)) bus ();

    conv_mc_engine #(.N(N), .P(P), .C(C), .SHIFT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;

    logic [7:0] kbuf [18];
    logic [7:0] pbuf [50];
    logic [7:0] res  [9];
    int         gaps [9];
    int         got;
    int         kacc;
    int         pacc;
    bit         stable_ok;
    bit         idle_ready_ok;
    bit         drop_ok;

    // done is a registered output held for a full cycle, so one negedge
    // sample per pulse.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_kern();
        bit hs;
        kacc = 0;
        for (int t = 0; t < 100 && kacc < 18; t++) begin
            @(negedge clk);
            bus.kern_valid = 1'b1;
            bus.kern_data  = kbuf[kacc];
            hs = bus.kern_ready;
            @(posedge clk);
            if (hs) kacc++;
        end
        @(negedge clk);
        bus.kern_valid = 1'b0;
    endtask

    task automatic send_pix(input int start_at);
        bit hs;
        pacc = 0;
        for (int t = 0; t < 200 && pacc < 50; t++) begin
            @(negedge clk);
            bus.pix_valid = 1'b1;
            bus.pix_data  = pbuf[pacc];
            bus.start     = (pacc == start_at);
            hs = bus.pix_ready;
            @(posedge clk);
            if (hs) pacc++;
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic collect(input bit stall);
        got           = 0;
        stable_ok     = 1'b1;
        idle_ready_ok = 1'b1;
        drop_ok       = 1'b1;
        for (int k = 0; k < 9; k++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (bus.out_valid !== 1'b1) break;
            gaps[k] = waited;
            res[k]  = bus.out_data;
            if (stall && k == 0) begin
                bus.kern_valid = 1'b1;
                bus.pix_valid  = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if (bus.out_valid !== 1'b1 || bus.out_data !== res[0]) stable_ok = 1'b0;
                    if (bus.kern_ready !== 1'b0 || bus.pix_ready !== 1'b0) idle_ready_ok = 1'b0;
                end
                bus.kern_valid = 1'b0;
                bus.pix_valid  = 1'b0;
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            if (bus.out_valid !== 1'b0) drop_ok = 1'b0;
            got++;
        end
    endtask

    task automatic run_job(input int start_at, input bit stall);
        pulse_start();
        send_kern();
        send_pix(start_at);
        collect(stall);
    endtask

    task automatic fill_uniform(input logic [7:0] kv, input logic [7:0] pv);
        for (int i = 0; i < 18; i++) kbuf[i] = kv;
        for (int i = 0; i < 50; i++) pbuf[i] = pv;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b0;
        @(negedge clk);
        obs = {bus.busy, bus.done, bus.out_valid, bus.kern_ready, bus.pix_ready, |bus.out_data};
        tests_run++;
        if (obs !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b expected 000000", obs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ones();
        int d0;
        fill_uniform(8'd1, 8'd1);
        d0 = done_cnt;
        run_job(-1, 1'b0);
        tests_run++;
        if (kacc !== 18) begin
            tests_failed++;
            $display("[TB] FAIL ones_kern_count: got %0d expected 18", kacc);
        end
        tests_run++;
        if (pacc !== 50) begin
            tests_failed++;
            $display("[TB] FAIL ones_pix_count: got %0d expected 50", pacc);
        end
        tests_run++;
        if (got !== 9) begin
            tests_failed++;
            $display("[TB] FAIL ones_out_count: got %0d expected 9", got);
        end
        for (int k = 0; k < got; k++) begin
            tests_run++;
            if (res[k] !== 8'd18) begin
                tests_failed++;
                $display("[TB] FAIL ones_out%0d: got %0d expected 18", k, res[k]);
            end
            tests_run++;
            if (gaps[k] !== 2) begin
                tests_failed++;
                $display("[TB] FAIL ones_latency%0d: got %0d idle negedges expected 2", k, gaps[k]);
            end
        end
        tests_run++;
        if (drop_ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ones_valid_drop: got %0d expected 1", drop_ok);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL ones_done_pulses: got %0d expected 1", done_cnt - d0);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ones_busy_after: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_uniform(input string name, input logic [7:0] kv,
                                input logic [7:0] pv, input logic [7:0] exp);
        fill_uniform(kv, pv);
        run_job(-1, 1'b0);
        tests_run++;
        if (got !== 9) begin
            tests_failed++;
            $display("[TB] FAIL %s_out_count: got %0d expected 9", name, got);
        end
        for (int k = 0; k < got; k++) begin
            tests_run++;
            if (res[k] !== exp) begin
                tests_failed++;
                $display("[TB] FAIL %s_out%0d: got 0x%02h expected 0x%02h", name, k, res[k], exp);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sat_pos();
        test_uniform("sat_pos", 8'd127, 8'd255, RELU ? 8'd255 : 8'd127);
    endtask

    task automatic test_sat_neg();
        test_uniform("sat_neg", 8'hFF, 8'd10, RELU ? 8'h00 : 8'h80);
    endtask

    task automatic test_unsigned_pixel();
        // Only the channel-0 centre tap is 1, so each result is one pixel.
        fill_uniform(8'd0, 8'd200);
        kbuf[4] = 8'd1;
        run_job(-1, 1'b0);
        tests_run++;
        if (got !== 9) begin
            tests_failed++;
            $display("[TB] FAIL unsigned_out_count: got %0d expected 9", got);
        end
        for (int k = 0; k < got; k++) begin
            tests_run++;
            if (res[k] !== (RELU ? 8'd200 : 8'd127)) begin
                tests_failed++;
                $display("[TB] FAIL unsigned_out%0d: got %0d expected %0d", k, res[k],
                         RELU ? 200 : 127);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stall_raster();
        int d0;
        logic [7:0] exp;
        fill_uniform(8'd0, 8'd0);
        kbuf[4] = 8'd1;
        for (int ch = 0; ch < 2; ch++)
            for (int i = 0; i < 25; i++) pbuf[ch * 25 + i] = 8'(i);
        d0 = done_cnt;
        run_job(-1, 1'b1);
        tests_run++;
        if (stable_ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_stable: got %0d expected 1", stable_ok);
        end
        tests_run++;
        if (idle_ready_ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_no_load_ready: got %0d expected 1", idle_ready_ok);
        end
        tests_run++;
        if (got !== 9) begin
            tests_failed++;
            $display("[TB] FAIL stall_out_count: got %0d expected 9", got);
        end
        for (int k = 0; k < got; k++) begin
            exp = 8'(5 * (k / 3 + 1) + (k % 3 + 1));
            tests_run++;
            if (res[k] !== exp) begin
                tests_failed++;
                $display("[TB] FAIL stall_raster%0d: got %0d expected %0d", k, res[k], exp);
            end
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL stall_done_pulses: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs;
        int d0;
        fill_uniform(8'd1, 8'd1);
        pulse_start();
        send_kern();
        send_pix(-1);
        rst = 1'b0;
        #1;
        obs = {bus.busy, bus.done, bus.out_valid, bus.kern_ready, bus.pix_ready, |bus.out_data};
        tests_run++;
        if (obs !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got %b expected 000000", obs);
        end
        @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_idle: got busy %b expected 0", bus.busy);
        end
        repeat (8) @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0 || done_cnt !== d0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_quiet: got out_valid %b done %0d expected 0 0",
                     bus.out_valid, done_cnt - d0);
        end
        run_job(-1, 1'b0);
        tests_run++;
        if (got !== 9) begin
            tests_failed++;
            $display("[TB] FAIL midreset_rerun_count: got %0d expected 9", got);
        end
        for (int k = 0; k < got; k++) begin
            tests_run++;
            if (res[k] !== 8'd18) begin
                tests_failed++;
                $display("[TB] FAIL midreset_rerun%0d: got %0d expected 18", k, res[k]);
            end
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_done_pulses: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_start_ignored();
        int d0;
        fill_uniform(8'd1, 8'd1);
        d0 = done_cnt;
        run_job(20, 1'b0);
        tests_run++;
        if (got !== 9) begin
            tests_failed++;
            $display("[TB] FAIL startign_out_count: got %0d expected 9", got);
        end
        for (int k = 0; k < got; k++) begin
            tests_run++;
            if (res[k] !== 8'd18) begin
                tests_failed++;
                $display("[TB] FAIL startign_out%0d: got %0d expected 18", k, res[k]);
            end
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("[TB] FAIL startign_done_pulses: got %0d expected 1", done_cnt - d0);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.kern_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL startign_no_restart: got busy %b kern_ready %b expected 0 0",
                     bus.busy, bus.kern_ready);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.kern_valid = 1'b0;
        bus.kern_data  = '0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_ones();
        test_sat_pos();
        test_sat_neg();
        test_unsigned_pixel();
        test_stall_raster();
        test_reset_mid();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] time limit");
    end
endmodule
